// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared slice state type and occupancy width helper
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } slot_state_t;

   // Counter must represent 0 .. 2*stages inclusive.
   function automatic int occ_width(input int stages);
      return $clog2(2 * stages + 1);
   endfunction

endpackage

// File: rtl/skid_slice.sv
// rtl/skid_slice.sv - one elastic slice: main register M, skid register S, registered ready
module skid_slice
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic             i_up_valid,
   output logic             o_up_ready,
   input  logic [WIDTH-1:0] i_up_data,
   output logic             o_dn_valid,
   input  logic             i_dn_ready,
   output logic [WIDTH-1:0] o_dn_data
);

   slot_state_t      r_state;
   slot_state_t      w_next;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_s;
   logic             r_ready;
   logic             w_acc;
   logic             w_rel;

   assign w_acc      = i_up_valid & r_ready;
   assign w_rel      = (r_state != EMPTY) & i_dn_ready;
   assign o_up_ready = r_ready;
   assign o_dn_valid = (r_state != EMPTY);
   assign o_dn_data  = r_m;

   always_comb begin
      w_next = r_state;
      case (r_state)
         EMPTY: if (w_acc) w_next = ONE;
         ONE: begin
            if (w_acc && !w_rel)      w_next = TWO;
            else if (!w_acc && w_rel) w_next = EMPTY;
         end
         TWO:     if (w_rel) w_next = ONE;
         default: w_next = EMPTY;
      endcase
   end

   // Ready is stored from the next state so it never sees the downstream ready combinationally.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= EMPTY;
         r_ready <= 1'b1;
         r_m     <= RESET_VAL;
         r_s     <= RESET_VAL;
      end else if (i_flush) begin
         r_state <= EMPTY;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next != TWO);
         if ((r_state == EMPTY && w_acc) || (r_state == ONE && w_acc && w_rel))
            r_m <= i_up_data;
         else if (r_state == TWO && w_rel)
            r_m <= r_s;
         if (r_state == ONE && w_acc && !w_rel)
            r_s <= i_up_data;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - chain of STAGES skid slices with occupancy count and flush/reset ready masking
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               STAGES    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_flush,
   input  logic                           i_in_valid,
   output logic                           o_in_ready,
   input  logic [WIDTH-1:0]               i_in,
   output logic                           o_out_valid,
   input  logic                           i_out_ready,
   output logic [WIDTH-1:0]               o_out,
   output logic [occ_width(STAGES)-1:0]   o_occupancy
);

   localparam int OCC_W = occ_width(STAGES);

   logic [STAGES:0]  w_valid;
   logic [STAGES:0]  w_ready;
   logic [WIDTH-1:0] w_data [STAGES+1];
   logic [OCC_W-1:0] r_occ;
   logic             w_in_xfer;
   logic             w_out_xfer;

   assign w_valid[0]      = i_in_valid;
   assign w_data[0]       = i_in;
   assign w_ready[STAGES] = i_out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      skid_slice #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_slice (
         .i_clk      (i_clk),
         .i_reset    (i_reset),
         .i_flush    (i_flush),
         .i_up_valid (w_valid[k]),
         .o_up_ready (w_ready[k]),
         .i_up_data  (w_data[k]),
         .o_dn_valid (w_valid[k+1]),
         .i_dn_ready (w_ready[k+1]),
         .o_dn_data  (w_data[k+1])
      );
   end

   assign o_in_ready  = w_ready[0] & ~i_flush & ~i_reset;
   assign o_out_valid = w_valid[STAGES];
   assign o_out       = w_data[STAGES];
   assign o_occupancy = r_occ;

   assign w_in_xfer  = i_in_valid & o_in_ready;
   assign w_out_xfer = o_out_valid & i_out_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_occ <= '0;
      end else if (w_in_xfer && !w_out_xfer) begin
         r_occ <= r_occ + OCC_W'(1);
      end else if (!w_in_xfer && w_out_xfer) begin
         r_occ <= r_occ - OCC_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed scoreboard bench over three parameterisations of pipe_stage_reg
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // DUT3: 32-bit, 3 stages, reset value 0
   logic        rst3, fl3, iv3, ir3, ov3, ordy3;
   logic [31:0] id3, od3;
   logic [2:0]  occ3;
   // DUT2: 8-bit, 2 stages, reset value 0
   logic        rst2, fl2, iv2, ir2, ov2, ordy2;
   logic [7:0]  id2, od2;
   logic [2:0]  occ2;
   // DUT1: 32-bit, 1 stage, reset value 32'h13
   logic        rst1, fl1, iv1, ir1, ov1, ordy1;
   logic [31:0] id1, od1;
   logic [1:0]  occ1;

   logic [31:0] q3[$];
   logic [7:0]  q2[$];
   logic [31:0] q1[$];

   int first_acc3, first_ov3, last_dv3, n_dv3, n_dv2;
   logic [7:0]  last_od2;
   logic [31:0] last_od1;

   pipe_stage_reg #(.WIDTH(32), .STAGES(3), .RESET_VAL(32'h0)) u_dut3 (
      .i_clk(clk), .i_reset(rst3), .i_flush(fl3), .i_in_valid(iv3), .o_in_ready(ir3), .i_in(id3),
      .o_out_valid(ov3), .i_out_ready(ordy3), .o_out(od3), .o_occupancy(occ3));

   pipe_stage_reg #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'h0)) u_dut2 (
      .i_clk(clk), .i_reset(rst2), .i_flush(fl2), .i_in_valid(iv2), .o_in_ready(ir2), .i_in(id2),
      .o_out_valid(ov2), .i_out_ready(ordy2), .o_out(od2), .o_occupancy(occ2));

   pipe_stage_reg #(.WIDTH(32), .STAGES(1), .RESET_VAL(32'h13)) u_dut1 (
      .i_clk(clk), .i_reset(rst1), .i_flush(fl1), .i_in_valid(iv1), .o_in_ready(ir1), .i_in(id1),
      .o_out_valid(ov1), .i_out_ready(ordy1), .o_out(od1), .o_occupancy(occ1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc3();
      #3;
      chk("occ3", 32'(occ3), 32'(q3.size()));
      if (ov3 && first_ov3 < 0) first_ov3 = cyc;
      if (ov3 && ordy3) begin
         chk("sb3_nonempty", 32'(q3.size() > 0), 32'd1);
         if (q3.size() > 0) chk("sb3_data", od3, q3.pop_front());
         last_dv3 = cyc;
         n_dv3++;
      end
      if (iv3 && ir3) begin
         q3.push_back(id3);
         if (first_acc3 < 0) first_acc3 = cyc;
      end
      @(posedge clk); #1; cyc++;
   endtask

   task automatic cyc2(output bit acc);
      #3;
      chk("occ2", 32'(occ2), 32'(q2.size()));
      acc = iv2 && ir2;
      if (ov2 && ordy2) begin
         chk("sb2_nonempty", 32'(q2.size() > 0), 32'd1);
         if (q2.size() > 0) chk("sb2_data", 32'(od2), 32'(q2.pop_front()));
         last_od2 = od2;
         n_dv2++;
      end
      if (fl2) q2.delete();
      else if (acc) q2.push_back(id2);
      @(posedge clk); #1; cyc++;
   endtask

   task automatic cyc1(output bit acc);
      logic r;
      #3;
      r = ir1;
      ordy1 = ~ordy1;
      #1;
      chk("ir1_no_comb_path", 32'(ir1), 32'(r));
      ordy1 = ~ordy1;
      #1;
      chk("occ1", 32'(occ1), 32'(q1.size()));
      acc = iv1 && ir1;
      if (rst1) begin
         q1.delete();
      end else begin
         if (ov1 && ordy1) begin
            chk("sb1_nonempty", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) chk("sb1_data", od1, q1.pop_front());
            last_od1 = od1;
         end
         if (fl1) q1.delete();
         else if (acc) q1.push_back(id1);
      end
      @(posedge clk); #1; cyc++;
   endtask

   initial begin
      bit a;
      int n, n_acc;
      rst3 = 1'b1; fl3 = 1'b0; iv3 = 1'b1; id3 = 32'hDEAD_BEEF; ordy3 = 1'b1;
      rst2 = 1'b1; fl2 = 1'b0; iv2 = 1'b0; id2 = 8'h0; ordy2 = 1'b0;
      rst1 = 1'b1; fl1 = 1'b0; iv1 = 1'b0; id1 = 32'h0; ordy1 = 1'b0;
      first_acc3 = -1; first_ov3 = -1; last_dv3 = 0; n_dv3 = 0; n_dv2 = 0;
      last_od2 = 8'h0; last_od1 = 32'h0;

      repeat (3) begin
         @(posedge clk); #1; cyc++;
         chk("rst_out3", od3, 32'h0);
         chk("rst_ov3", 32'(ov3), 32'd0);
         chk("rst_ir3", 32'(ir3), 32'd0);
         chk("rst_occ3", 32'(occ3), 32'd0);
      end
      chk("rst_out1", od1, 32'h13);
      rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0; iv3 = 1'b0;
      #1;
      chk("rel_ir3", 32'(ir3), 32'd1);
      chk("rel_ir2", 32'(ir2), 32'd1);
      chk("rel_ir1", 32'(ir1), 32'd1);

      // Streaming through three stages
      for (int i = 1; i <= 10; i++) begin
         iv3 = 1'b1;
         id3 = 32'(i);
         chk("s3_ir", 32'(ir3), 32'd1);
         cyc3();
      end
      iv3 = 1'b0;
      n = 0;
      while (n_dv3 < 10 && n < 30) begin
         cyc3();
         n++;
      end
      chk("s3_count", 32'(n_dv3), 32'd10);
      chk("s3_latency", 32'(first_ov3 - first_acc3), 32'd3);
      chk("s3_nogap", 32'(last_dv3 - first_ov3), 32'd9);
      chk("s3_empty", 32'(q3.size()), 32'd0);

      // Backpressure into two stages
      ordy2 = 1'b0; iv2 = 1'b1; id2 = 8'd1; n = 0;
      repeat (8) begin
         cyc2(a);
         if (a) begin n++; id2 = id2 + 8'd1; end
      end
      chk("bp_acc", 32'(n), 32'd4);
      chk("bp_occ", 32'(occ2), 32'd4);
      chk("bp_ir", 32'(ir2), 32'd0);
      chk("bp_ov", 32'(ov2), 32'd1);
      ordy2 = 1'b1; n_dv2 = 0;
      repeat (10) begin
         cyc2(a);
         if (a) id2 = id2 + 8'd1;
      end
      chk("bp_resume", 32'(n_dv2), 32'd10);
      iv2 = 1'b0; n = 0;
      while (q2.size() > 0 && n < 20) begin cyc2(a); n++; end
      chk("bp_drain", 32'(q2.size()), 32'd0);

      // Flush with three entries held
      ordy2 = 1'b0; iv2 = 1'b1; id2 = 8'h10; n = 0; n_acc = 0;
      while (n_acc < 3 && n < 10) begin
         cyc2(a);
         if (a) begin n_acc++; id2 = id2 + 8'd1; end
         n++;
      end
      iv2 = 1'b0;
      #1;
      chk("fl_pre_occ", 32'(occ2), 32'd3);
      fl2 = 1'b1; iv2 = 1'b1; id2 = 8'hAA;
      #1;
      chk("fl_ir", 32'(ir2), 32'd0);
      cyc2(a);
      fl2 = 1'b0; iv2 = 1'b1; id2 = 8'h55; ordy2 = 1'b1;
      #1;
      chk("fl_ov", 32'(ov2), 32'd0);
      chk("fl_occ", 32'(occ2), 32'd0);
      cyc2(a);
      chk("fl_acc55", 32'(a), 32'd1);
      iv2 = 1'b0; n = 0; n_dv2 = 0;
      while (n_dv2 < 1 && n < 10) begin cyc2(a); n++; end
      chk("fl_55", 32'(last_od2), 32'h55);
      chk("fl_empty", 32'(q2.size()), 32'd0);

      // Random stall on a single stage
      for (int i = 0; i < 1000; i++) begin
         iv1   = 1'($urandom_range(0, 1));
         id1   = $urandom;
         ordy1 = 1'($urandom_range(0, 1));
         cyc1(a);
      end

      // Reset and flush together mid-stream
      iv1 = 1'b1; ordy1 = 1'b0; id1 = 32'h100;
      cyc1(a);
      id1 = 32'h101;
      cyc1(a);
      rst1 = 1'b1; fl1 = 1'b1; id1 = 32'hEE;
      #1;
      chk("rf_ir", 32'(ir1), 32'd0);
      cyc1(a);
      rst1 = 1'b0; fl1 = 1'b0; iv1 = 1'b1; id1 = 32'h77; ordy1 = 1'b1;
      #1;
      chk("rf_out", od1, 32'h13);
      chk("rf_occ", 32'(occ1), 32'd0);
      chk("rf_ov", 32'(ov1), 32'd0);
      cyc1(a);
      chk("rf_acc77", 32'(a), 32'd1);
      iv1 = 1'b0; n = 0;
      while (q1.size() > 0 && n < 10) begin cyc1(a); n++; end
      chk("rf_77", last_od1, 32'h77);
      chk("rf_empty", 32'(q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
